// File: rtl/pong_text_pkg.sv
// rtl/pong_text_pkg.sv - mode encodings, overlay geometry and character codes for the Pong text engine
package pong_text_pkg;

    typedef enum logic [1:0] {
        MODE_TITLE = 2'b00,
        MODE_PLAY  = 2'b01,
        MODE_OVER  = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        BCD_IDLE  = 2'b00,
        BCD_SHIFT = 2'b01,
        BCD_DONE  = 2'b10
    } bcd_state_e;

    localparam logic [10:0] BANNER_X0 = 11'd160;
    localparam logic [10:0] BANNER_X1 = 11'd448;
    localparam logic [10:0] BANNER_Y0 = 11'd192;
    localparam logic [10:0] BANNER_Y1 = 11'd256;
    localparam logic [10:0] LOGO_X0   = 11'd192;
    localparam logic [10:0] LOGO_X1   = 11'd448;
    localparam logic [10:0] LOGO_Y0   = 11'd256;
    localparam logic [10:0] LOGO_Y1   = 11'd384;

    localparam logic [6:0] CH_BLANK = 7'h00;
    localparam logic [6:0] CH_SPACE = 7'h20;
    localparam logic [6:0] CH_DIGIT = 7'h30;
    localparam logic [6:0] CH_A     = 7'h41;
    localparam logic [6:0] CH_E     = 7'h45;
    localparam logic [6:0] CH_G     = 7'h47;
    localparam logic [6:0] CH_M     = 7'h4D;
    localparam logic [6:0] CH_N     = 7'h4E;
    localparam logic [6:0] CH_O     = 7'h4F;
    localparam logic [6:0] CH_P     = 7'h50;
    localparam logic [6:0] CH_R     = 7'h52;
    localparam logic [6:0] CH_V     = 7'h56;

    // Encoding 11 is an alias of PLAY.
    function automatic mode_e norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_PLAY : mode_e'(m);
    endfunction

    function automatic logic [6:0] banner_char(input logic [3:0] idx);
        case (idx)
            4'd0:    return CH_G;
            4'd1:    return CH_A;
            4'd2:    return CH_M;
            4'd3:    return CH_E;
            4'd5:    return CH_O;
            4'd6:    return CH_V;
            4'd7:    return CH_E;
            4'd8:    return CH_R;
            default: return CH_SPACE;
        endcase
    endfunction

    function automatic logic [6:0] logo_char(input logic [1:0] idx);
        case (idx)
            2'd0:    return CH_P;
            2'd1:    return CH_O;
            2'd2:    return CH_N;
            default: return CH_G;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter with saturation
module bin2bcd_seq
    import pong_text_pkg::*;
#(
    parameter int W      = 7,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [W-1:0]          bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int          BW    = 4 * DIGITS;
    localparam int          CW    = $clog2(W + 1);
    localparam int unsigned LIMIT = 10 ** DIGITS;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    bcd_state_e    state_q, state_d;
    logic [W-1:0]  bin_q, bin_d;
    logic [BW-1:0] acc_q, acc_d, adj;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sat_q, sat_d;

    // Values below 10^DIGITS never overflow the DIGITS-nibble accumulator, so
    // only the saturation flag needs the full-range comparison.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        adj     = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            BCD_IDLE: begin
                if (start) begin
                    state_d = BCD_SHIFT;
                    bin_d   = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = (32'(bin) >= LIMIT);
                end
            end
            BCD_SHIFT: begin
                acc_d = {adj[BW-2:0], bin_q[W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = BCD_DONE;
                end
            end
            BCD_DONE: state_d = BCD_IDLE;
            default:  state_d = BCD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BCD_IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign busy = (state_q != BCD_IDLE);
    assign done = (state_q == BCD_DONE);
    assign bcd  = sat_q ? {DIGITS{4'h9}} : acc_q;

endmodule

// File: rtl/pong_text_engine.sv
// rtl/pong_text_engine.sv - score, banner and logo text overlay with a 2-cycle registered pixel pipeline
module pong_text_engine
    import pong_text_pkg::*;
#(
    parameter int          SCORE_W      = 7,
    parameter int          DIGITS       = 2,
    parameter int          SCORE_Y      = 0,
    parameter int          S1_X         = 192,
    parameter int          S2_X         = 384,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] BG_RGB       = 12'h0FF,
    parameter logic [11:0] FG_RGB       = 12'h00F,
    parameter logic [11:0] LOGO_RGB     = 12'h000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [1:0]         mode,
    input  logic [SCORE_W-1:0] score1,
    input  logic [SCORE_W-1:0] score2,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    output logic [10:0]        rom_addr,
    input  logic [7:0]         rom_data,
    output logic [3:0]         text_on,
    output logic [11:0]        text_rgb
);

    localparam int          BW      = 4 * DIGITS;
    localparam int          FCW     = $clog2(BLINK_FRAMES + 1);
    localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);
    localparam logic [10:0] S1_X0   = 11'(S1_X);
    localparam logic [10:0] S1_X1   = 11'(S1_X + 32 * DIGITS);
    localparam logic [10:0] S2_X0   = 11'(S2_X);
    localparam logic [10:0] S2_X1   = 11'(S2_X + 32 * DIGITS);
    localparam logic [10:0] SC_Y0   = 11'(SCORE_Y);
    localparam logic [10:0] SC_Y1   = 11'(SCORE_Y + 64);
    localparam logic [9:0]  S1_XV   = 10'(S1_X);
    localparam logic [9:0]  S2_XV   = 10'(S2_X);
    localparam logic [9:0]  SC_YV   = 10'(SCORE_Y);
    localparam logic [9:0]  BX_V    = BANNER_X0[9:0];
    localparam logic [9:0]  BY_V    = BANNER_Y0[9:0];
    localparam logic [9:0]  LX_V    = LOGO_X0[9:0];
    localparam logic [9:0]  LY_V    = LOGO_Y0[9:0];

    mode_e          mode_q, mode_d;
    logic           blink_vis_q, blink_vis_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic [BW-1:0]  disp1_q, disp1_d, disp2_q, disp2_d;
    logic [BW-1:0]  bcd1, bcd2;
    logic           busy1, busy2, done1, done2, conv_start;
    logic [3:0]     sel_q, sel_d;
    logic [2:0]     bit_q, bit_d;
    logic [3:0]     text_on_q, text_on_d;
    logic [11:0]    text_rgb_q, text_rgb_d;
    logic [10:0]    xe, ye;
    logic           in_s1, in_s2, in_ov, in_lg;
    logic           en_score, en_over, en_logo;
    logic           hit_s1, hit_s2, hit_ov, hit_lg;
    logic [6:0]     ch;
    logic [3:0]     row;
    logic           pix;

    assign conv_start = frame_start & ~busy1 & ~busy2;

    bin2bcd_seq #(.W(SCORE_W), .DIGITS(DIGITS)) u_bcd1 (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (score1),
        .busy  (busy1),
        .done  (done1),
        .bcd   (bcd1)
    );

    bin2bcd_seq #(.W(SCORE_W), .DIGITS(DIGITS)) u_bcd2 (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (score2),
        .busy  (busy2),
        .done  (done2),
        .bcd   (bcd2)
    );

    // Leading zeros blank out; the least-significant digit always shows.
    function automatic logic [6:0] score_char(input logic [BW-1:0] bcd, input logic [4:0] d);
        logic       lead;
        logic [6:0] c;
        lead = 1'b1;
        c    = CH_BLANK;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd[4*i +: 4] != 4'd0 || i == 0) begin
                lead = 1'b0;
            end
            if (int'(d) == DIGITS - 1 - i) begin
                c = lead ? CH_BLANK : (CH_DIGIT | {3'b000, bcd[4*i +: 4]});
            end
        end
        return c;
    endfunction

    always_comb begin
        mode_d      = mode_q;
        fcnt_d      = fcnt_q;
        blink_vis_d = blink_vis_q;
        if (frame_start) begin
            mode_d = norm_mode(mode);
            if (mode_q != MODE_OVER) begin
                if (norm_mode(mode) == MODE_OVER) begin
                    fcnt_d      = '0;
                    blink_vis_d = 1'b1;
                end
            end else if (fcnt_q == FC_LAST) begin
                fcnt_d      = '0;
                blink_vis_d = ~blink_vis_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        // Both converters start together, so both DONE states coincide.
        disp1_d = (done1 & done2) ? bcd1 : disp1_q;
        disp2_d = (done1 & done2) ? bcd2 : disp2_q;
    end

    always_comb begin
        xe       = {1'b0, x};
        ye       = {1'b0, y};
        in_s1    = (xe >= S1_X0) && (xe < S1_X1) && (ye >= SC_Y0) && (ye < SC_Y1);
        in_s2    = (xe >= S2_X0) && (xe < S2_X1) && (ye >= SC_Y0) && (ye < SC_Y1);
        in_ov    = (xe >= BANNER_X0) && (xe < BANNER_X1) && (ye >= BANNER_Y0) && (ye < BANNER_Y1);
        in_lg    = (xe >= LOGO_X0) && (xe < LOGO_X1) && (ye >= LOGO_Y0) && (ye < LOGO_Y1);
        en_score = (mode_q == MODE_PLAY) || (mode_q == MODE_OVER);
        en_logo  = (mode_q == MODE_TITLE) || (mode_q == MODE_PLAY);
        en_over  = (mode_q == MODE_OVER) && blink_vis_q;
        hit_s1   = in_s1 & en_score;
        hit_s2   = in_s2 & en_score & ~hit_s1;
        hit_ov   = in_ov & en_over & ~hit_s1 & ~hit_s2;
        hit_lg   = in_lg & en_logo & ~hit_s1 & ~hit_s2 & ~hit_ov;
        ch       = CH_BLANK;
        row      = 4'd0;
        bit_d    = 3'd0;
        if (hit_s1) begin
            ch    = score_char(disp1_q, 5'((x - S1_XV) >> 5));
            row   = 4'((y - SC_YV) >> 2);
            bit_d = 3'((x - S1_XV) >> 2);
        end else if (hit_s2) begin
            ch    = score_char(disp2_q, 5'((x - S2_XV) >> 5));
            row   = 4'((y - SC_YV) >> 2);
            bit_d = 3'((x - S2_XV) >> 2);
        end else if (hit_ov) begin
            ch    = banner_char(4'((x - BX_V) >> 5));
            row   = 4'((y - BY_V) >> 2);
            bit_d = 3'((x - BX_V) >> 2);
        end else if (hit_lg) begin
            ch    = logo_char(2'((x - LX_V) >> 6));
            row   = 4'((y - LY_V) >> 3);
            bit_d = 3'((x - LX_V) >> 3);
        end
        sel_d = {hit_lg, hit_s1, hit_s2, hit_ov};
    end

    assign rom_addr = {ch, row};

    // Bit 7 of the ROM byte is the leftmost pixel of the glyph row.
    always_comb begin
        pix       = rom_data[~bit_q];
        text_on_d = sel_q;
        if (sel_q == 4'd0 || !pix) begin
            text_rgb_d = BG_RGB;
        end else if (sel_q[3]) begin
            text_rgb_d = LOGO_RGB;
        end else begin
            text_rgb_d = FG_RGB;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= MODE_TITLE;
            fcnt_q      <= '0;
            blink_vis_q <= 1'b1;
            disp1_q     <= '0;
            disp2_q     <= '0;
            sel_q       <= '0;
            bit_q       <= '0;
            text_on_q   <= '0;
            text_rgb_q  <= BG_RGB;
        end else begin
            mode_q      <= mode_d;
            fcnt_q      <= fcnt_d;
            blink_vis_q <= blink_vis_d;
            disp1_q     <= disp1_d;
            disp2_q     <= disp2_d;
            sel_q       <= sel_d;
            bit_q       <= bit_d;
            text_on_q   <= text_on_d;
            text_rgb_q  <= text_rgb_d;
        end
    end

    assign text_on  = text_on_q;
    assign text_rgb = text_rgb_q;

endmodule

// File: tb/tb_pong_text_engine.sv
// tb/tb_pong_text_engine.sv - directed self-checking bench for pong_text_engine
module tb_pong_text_engine;

    localparam int          SW = 7;
    localparam logic [11:0] BG = 12'h0FF;
    localparam logic [11:0] FG = 12'h00F;
    localparam logic [11:0] LG = 12'h000;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [1:0]  mode;
    logic [6:0]  score1, score2;
    logic [9:0]  x, y;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  text_on;
    logic [11:0] text_rgb;

    int n_checks = 0;
    int n_fail   = 0;

    pong_text_engine #(.BLINK_FRAMES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .mode        (mode),
        .score1      (score1),
        .score2      (score2),
        .x           (x),
        .y           (y),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .text_on     (text_on),
        .text_rgb    (text_rgb)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        if (a[10:4] == 7'd0) return 8'd0;
        return 8'(a[7:0] * 8'd37) ^ {1'b0, a[10:4]};
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_conv();
        repeat (SW + 2) @(negedge clk);
    endtask

    task automatic probe(input string tag, input int px, input int py, input logic [3:0] exp_on,
                         input logic [6:0] ch, input logic [3:0] row, input logic [2:0] b,
                         input logic [11:0] fg);
        logic [7:0]  g;
        logic [11:0] er;
        @(negedge clk);
        x = 10'(px);
        y = 10'(py);
        @(negedge clk);
        @(negedge clk);
        g  = rom_fn({ch, row});
        er = (exp_on != 4'd0 && g[7 - int'(b)]) ? fg : BG;
        check_eq({tag, "_on"}, 32'(text_on), 32'(exp_on));
        check_eq({tag, "_rgb"}, 32'(text_rgb), 32'(er));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  logo_chars [4];
        int          p, idx;
        logic [7:0]  g;
        logic [3:0]  eon;
        logic [11:0] ergb;
        logo_chars = '{7'h50, 7'h4F, 7'h4E, 7'h47};

        reset = 1'b1; frame_start = 1'b0; mode = 2'b00;
        score1 = 7'd0; score2 = 7'd0; x = 10'd0; y = 10'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_on", 32'(text_on), 32'h0);
        check_eq("rst_rgb", 32'(text_rgb), 32'(BG));
        check_eq("rst_disp1", 32'(dut.disp1_q), 32'h0);
        check_eq("rst_busy", 32'(dut.busy1), 32'h0);

        // Single-digit and two-digit scores in PLAY
        mode = 2'b01; score1 = 7'd7; score2 = 7'd42;
        pulse_frame();
        wait_conv();
        check_eq("t1_disp1", 32'(dut.disp1_q), 32'h07);
        check_eq("t1_disp2", 32'(dut.disp2_q), 32'h42);
        probe("t1_s1_tens", 200, 10, 4'b0100, 7'h00, 4'd2, 3'd2, FG);
        probe("t1_s1_unit", 236, 10, 4'b0100, 7'h37, 4'd2, 3'd3, FG);
        probe("t1_s2_tens", 390, 20, 4'b0010, 7'h34, 4'd5, 3'd1, FG);
        probe("t1_s2_unit", 430, 20, 4'b0010, 7'h32, 4'd5, 3'd3, FG);
        probe("t1_outside", 100, 10, 4'b0000, 7'h00, 4'd0, 3'd0, FG);
        probe("t1_logo", 300, 300, 4'b1000, 7'h4F, 4'd5, 3'd5, LG);

        // Saturation and zero
        score1 = 7'd123; score2 = 7'd0;
        pulse_frame();
        wait_conv();
        check_eq("t2_disp1", 32'(dut.disp1_q), 32'h99);
        check_eq("t2_disp2", 32'(dut.disp2_q), 32'h00);
        probe("t2_s1_tens", 200, 10, 4'b0100, 7'h39, 4'd2, 3'd2, FG);
        probe("t2_s1_unit", 236, 10, 4'b0100, 7'h39, 4'd2, 3'd3, FG);
        probe("t2_s2_tens", 390, 20, 4'b0010, 7'h00, 4'd5, 3'd1, FG);
        probe("t2_s2_unit", 430, 20, 4'b0010, 7'h30, 4'd5, 3'd3, FG);

        // GAME OVER blink with a 2-frame half-period
        mode = 2'b10;
        for (int f = 0; f < 6; f++) begin
            pulse_frame();
            probe($sformatf("t3_banner_f%0d", f), 164, 200,
                  (f < 2 || f >= 4) ? 4'b0001 : 4'b0000, 7'h47, 4'd2, 3'd1, FG);
            probe($sformatf("t3_score_f%0d", f), 236, 10, 4'b0100, 7'h39, 4'd2, 3'd3, FG);
        end

        // Mode change takes effect only at frame_start
        mode = 2'b00;
        pulse_frame();
        probe("t4_title_score", 236, 10, 4'b0000, 7'h00, 4'd0, 3'd0, FG);
        probe("t4_title_logo", 300, 300, 4'b1000, 7'h4F, 4'd5, 3'd5, LG);
        mode = 2'b11;
        probe("t4_mid_frame", 236, 10, 4'b0000, 7'h00, 4'd0, 3'd0, FG);
        pulse_frame();
        probe("t4_play_score", 236, 10, 4'b0100, 7'h39, 4'd2, 3'd3, FG);

        // Full-row sweep through the logo, with wrap back to x=0
        y = 10'd300;
        for (int j = 0; j < 644; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                p = (j - 2) % 640;
                if (p >= 192 && p < 448) begin
                    idx  = (p - 192) / 64;
                    g    = rom_fn({logo_chars[idx], 4'd5});
                    eon  = 4'b1000;
                    ergb = g[7 - ((p - 192) / 8) % 8] ? LG : BG;
                end else begin
                    eon  = 4'b0000;
                    ergb = BG;
                end
                check_eq($sformatf("t5_on_x%0d", p), 32'(text_on), 32'(eon));
                check_eq($sformatf("t5_rgb_x%0d", p), 32'(text_rgb), 32'(ergb));
            end
            x = 10'(j % 640);
        end

        // Reset in the middle of a conversion
        score1 = 7'd55; score2 = 7'd66;
        @(negedge clk);
        x = 10'd200; y = 10'd10;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        check_eq("t6_pre_on", 32'(text_on), 32'b0100);
        check_eq("t6_pre_busy", 32'(dut.busy1), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("t6_on", 32'(text_on), 32'h0);
        check_eq("t6_rgb", 32'(text_rgb), 32'(BG));
        check_eq("t6_busy1", 32'(dut.busy1), 32'h0);
        check_eq("t6_busy2", 32'(dut.busy2), 32'h0);
        check_eq("t6_disp1", 32'(dut.disp1_q), 32'h0);
        repeat (SW + 4) @(negedge clk);
        check_eq("t6_hold1", 32'(dut.disp1_q), 32'h0);
        check_eq("t6_hold2", 32'(dut.disp2_q), 32'h0);
        mode = 2'b01;
        pulse_frame();
        wait_conv();
        check_eq("t6_disp1_new", 32'(dut.disp1_q), 32'h55);
        check_eq("t6_disp2_new", 32'(dut.disp2_q), 32'h66);
        probe("t6_s1_unit", 236, 10, 4'b0100, 7'h35, 4'd2, 3'd3, FG);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
